// File: rtl/gshare_predictor_pkg.sv
// rtl/gshare_predictor_pkg.sv - shared types and constants for the gshare predictor
// Purpose: FSM state encoding, write-enable levels and the counter init value.
// Ports: none (package).
package gshare_predictor_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Weakly not-taken: 2**(ctr_w-1)-1, e.g. 2'b01 for 2-bit counters.
  function automatic int unsigned cinit_of(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter_update.sv
// rtl/sat_counter_update.sv - saturating up/down counter next-value logic
// Purpose: combinational next value for one direction counter.
// Ports:
//   cur_i   in  CTR_W  current counter value
//   taken_i in  1      1 = increment (saturate at all-ones), 0 = decrement (saturate at 0)
//   next_o  out CTR_W  updated counter value
module sat_counter_update #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] cur_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] next_o
);

  always_comb begin
    next_o = cur_i;
    if (taken_i) begin
      if (!(&cur_i)) next_o = cur_i + CTR_W'(1);
    end else begin
      if (|cur_i) next_o = cur_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare branch direction predictor with self-clearing table
// Purpose: zero-latency direction lookup for IF, training from EX, speculative history
//   with mispredict recovery, and a post-reset sweep that initialises every counter.
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   pc_from_if, query_from_if      fetch PC and "conditional branch here" strobe
//   ready_to_if                    0 while the table is being swept
//   prediction_to_if               predicted direction (1 = taken)
//   idx_to_if, ghr_to_if           index used and pre-shift history, carried down the pipe
//   flag_from_ex                   EX resolves a conditional branch
//   idx_from_ex, ghr_from_ex       index/history snapshot returned by EX
//   branch_from_ex, mispred_from_ex actual outcome and mispredict flag
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int IDX_W  = 8,
  parameter int CTR_W  = 2,
  parameter int GHR_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_from_if,
  input  logic              query_from_if,
  output logic              ready_to_if,
  output logic              prediction_to_if,
  output logic [IDX_W-1:0]  idx_to_if,
  output logic [GHR_W-1:0]  ghr_to_if,
  input  logic              flag_from_ex,
  input  logic [IDX_W-1:0]  idx_from_ex,
  input  logic [GHR_W-1:0]  ghr_from_ex,
  input  logic              branch_from_ex,
  input  logic              mispred_from_ex
);

  localparam int               DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CINIT = CTR_W'(cinit_of(CTR_W));

  logic [CTR_W-1:0] table_q [DEPTH];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;

  logic             run;
  logic             pred;
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] idx;
  logic [CTR_W-1:0] rd_ctr;
  logic [CTR_W-1:0] ex_ctr;
  logic [CTR_W-1:0] ex_next;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_data;

  // Word-address bits outside the index and the history MSB shifted out on recovery.
  logic unused_ok;
  assign unused_ok = ^{pc_from_if[ADDR_W-1:IDX_W+2], pc_from_if[1:0], ghr_from_ex[GHR_W-1]};

  // Lookup: history is zero-extended into the low index bits.
  always_comb begin
    ghr_ext            = '0;
    ghr_ext[GHR_W-1:0] = ghr_q;
    idx                = pc_from_if[IDX_W+1:2] ^ ghr_ext;
    rd_ctr             = table_q[idx];
    run                = (state_q == ST_RUN) && !rst;
    pred               = run & rd_ctr[CTR_W-1];
  end

  assign ready_to_if      = run;
  assign prediction_to_if = pred;
  assign idx_to_if        = rst ? '0 : idx;
  assign ghr_to_if        = rst ? '0 : ghr_q;

  assign ex_ctr = table_q[idx_from_ex];

  sat_counter_update #(
    .CTR_W (CTR_W)
  ) u_sat_counter_update (
    .cur_i   (ex_ctr),
    .taken_i (branch_from_ex),
    .next_o  (ex_next)
  );

  // Single table write port: the sweep owns it in INIT, EX training in RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ghr_d   = ghr_q;
    wr_en   = DISABLE;
    wr_idx  = ptr_q;
    wr_data = CINIT;

    if (state_q == ST_INIT) begin
      wr_en = ENABLE;
      ptr_d = ptr_q + IDX_W'(1);
      ghr_d = '0;
      if (ptr_q == {IDX_W{1'b1}}) state_d = ST_RUN;
    end else begin
      if (flag_from_ex) begin
        wr_en   = ENABLE;
        wr_idx  = idx_from_ex;
        wr_data = ex_next;
      end
      // Recovery takes priority; a same-cycle query shift is on the wrong path.
      if (flag_from_ex && mispred_from_ex) begin
        ghr_d[0] = branch_from_ex;
        for (int i = 1; i < GHR_W; i++) ghr_d[i] = ghr_from_ex[i-1];
      end else if (query_from_if) begin
        ghr_d[0] = pred;
        for (int i = 1; i < GHR_W; i++) ghr_d[i] = ghr_q[i-1];
      end
    end

    if (rst) wr_en = DISABLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) table_q[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - self-checking bench for gshare_predictor
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_from_if;
  logic        query_from_if;
  logic        ready_to_if;
  logic        prediction_to_if;
  logic [7:0]  idx_to_if;
  logic [7:0]  ghr_to_if;
  logic        flag_from_ex;
  logic [7:0]  idx_from_ex;
  logic [7:0]  ghr_from_ex;
  logic        branch_from_ex;
  logic        mispred_from_ex;

  gshare_predictor #(
    .IDX_W  (8),
    .CTR_W  (2),
    .GHR_W  (8),
    .ADDR_W (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_from_if       (pc_from_if),
    .query_from_if    (query_from_if),
    .ready_to_if      (ready_to_if),
    .prediction_to_if (prediction_to_if),
    .idx_to_if        (idx_to_if),
    .ghr_to_if        (ghr_to_if),
    .flag_from_ex     (flag_from_ex),
    .idx_from_ex      (idx_from_ex),
    .ghr_from_ex      (ghr_from_ex),
    .branch_from_ex   (branch_from_ex),
    .mispred_from_ex  (mispred_from_ex)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs;
  logic [31:0] exp_v;
  int          mdl[256];
  int          mghr;
  int          n;

  function automatic int sat(input int c, input bit t);
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  function automatic int shl(input int g, input int b);
    return ((g << 1) | b) & 255;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    query_from_if   = 1'b0;
    flag_from_ex    = 1'b0;
    mispred_from_ex = 1'b0;
    branch_from_ex  = 1'b0;
    idx_from_ex     = 8'h00;
    ghr_from_ex     = 8'h00;
  endtask

  task automatic test_reset;
    idle();
    rst = 1'b1;
    pc_from_if = 32'h44;
    query_from_if = 1'b1;
    cyc();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    obs = 32'(ready_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_ready got %0h expected %0h", obs, exp_v); end
    obs = 32'(prediction_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_pred got %0h expected %0h", obs, exp_v); end
    obs = 32'(idx_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_idx got %0h expected %0h", obs, exp_v); end
    obs = 32'(ghr_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_ghr got %0h expected %0h", obs, exp_v); end

    rst = 1'b0;
    n = 0;
    while (ready_to_if !== 1'b1 && n < 600) begin
      cyc();
      n++;
      if (n == 128) begin
        exp_q.push_back(32'd0);
        obs = 32'(prediction_to_if); exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL init_pred_mid got %0h expected %0h", obs, exp_v); end
      end
    end
    exp_q.push_back(32'd256);
    obs = 32'(n); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL init_sweep_len got %0d expected %0d", obs, exp_v); end

    query_from_if = 1'b0;
    for (int i = 0; i < 256; i++) mdl[i] = 1;
    mghr = 0;
    for (int i = 0; i < 256; i++) begin
      pc_from_if = 32'(i << 2);
      #1;
      exp_q.push_back(32'(mdl[i]));
      exp_q.push_back(32'(mdl[i] >= 2));
      obs = 32'(dut.table_q[i]); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL init_table[%0d] got %0h expected %0h", i, obs, exp_v); end
      obs = 32'(prediction_to_if); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL init_pred[%0d] got %0h expected %0h", i, obs, exp_v); end
    end
  endtask

  task automatic test_saturation;
    idle();
    pc_from_if   = 32'h40;
    flag_from_ex = 1'b1;
    idx_from_ex  = 8'h10;
    for (int k = 0; k < 8; k++) begin
      branch_from_ex = (k < 4);
      mdl[16] = sat(mdl[16], k < 4);
      exp_q.push_back(32'(mdl[16]));
      exp_q.push_back(32'(mdl[16] >= 2));
      cyc();
      obs = 32'(dut.table_q[16]); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL sat_ctr step%0d got %0h expected %0h", k, obs, exp_v); end
      obs = 32'(prediction_to_if); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL sat_pred step%0d got %0h expected %0h", k, obs, exp_v); end
    end
    idle();
  endtask

  task automatic test_history;
    idle();
    pc_from_if    = 32'h40;
    query_from_if = 1'b1;
    #1;
    exp_q.push_back(32'(mdl[(16 ^ mghr) & 255] >= 2));
    obs = 32'(prediction_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hist_pred0 got %0h expected %0h", obs, exp_v); end
    mghr = shl(mghr, (mdl[(16 ^ mghr) & 255] >= 2) ? 1 : 0);
    cyc();
    query_from_if = 1'b0;
    exp_q.push_back(32'(mghr));
    obs = 32'(ghr_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hist_ghr0 got %0h expected %0h", obs, exp_v); end

    flag_from_ex   = 1'b1;
    idx_from_ex    = 8'h10;
    branch_from_ex = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mdl[16] = sat(mdl[16], 1'b1);
      cyc();
    end
    idle();
    query_from_if = 1'b1;
    #1;
    exp_q.push_back(32'(mdl[(16 ^ mghr) & 255] >= 2));
    obs = 32'(prediction_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hist_pred1 got %0h expected %0h", obs, exp_v); end
    mghr = shl(mghr, (mdl[(16 ^ mghr) & 255] >= 2) ? 1 : 0);
    cyc();
    query_from_if = 1'b0;
    #1;
    exp_q.push_back(32'(mghr));
    exp_q.push_back(32'((16 ^ mghr) & 255));
    obs = 32'(ghr_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hist_ghr1 got %0h expected %0h", obs, exp_v); end
    obs = 32'(idx_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hist_idx got %0h expected %0h", obs, exp_v); end
  endtask

  task automatic test_recovery;
    idle();
    flag_from_ex    = 1'b1;
    mispred_from_ex = 1'b1;
    idx_from_ex     = 8'hF0;
    ghr_from_ex     = 8'h52;
    branch_from_ex  = 1'b1;
    mdl[240] = sat(mdl[240], 1'b1);
    mghr = shl(32'h52, 1);
    cyc();
    idle();
    exp_q.push_back(32'(mghr));
    obs = 32'(ghr_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rec_setup_ghr got %0h expected %0h", obs, exp_v); end

    flag_from_ex    = 1'b1;
    mispred_from_ex = 1'b1;
    idx_from_ex     = 8'hF1;
    ghr_from_ex     = 8'h3C;
    branch_from_ex  = 1'b1;
    query_from_if   = 1'b1;
    pc_from_if      = 32'h1234;
    #1;
    exp_q.push_back(32'(((32'h1234 >> 2) ^ mghr) & 255));
    obs = 32'(idx_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rec_idx got %0h expected %0h", obs, exp_v); end
    mdl[241] = sat(mdl[241], 1'b1);
    mghr = shl(32'h3C, 1);
    cyc();
    idle();
    exp_q.push_back(32'(mghr));
    obs = 32'(ghr_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rec_ghr got %0h expected %0h", obs, exp_v); end

    mispred_from_ex = 1'b1;
    ghr_from_ex     = 8'hFF;
    branch_from_ex  = 1'b1;
    idx_from_ex     = 8'hF2;
    cyc();
    idle();
    exp_q.push_back(32'(mghr));
    exp_q.push_back(32'(mdl[242]));
    obs = 32'(ghr_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rec_noflag_ghr got %0h expected %0h", obs, exp_v); end
    obs = 32'(dut.table_q[242]); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rec_noflag_ctr got %0h expected %0h", obs, exp_v); end
  endtask

  task automatic test_hazard;
    idle();
    pc_from_if     = 32'(((34 ^ mghr) & 255) << 2);
    query_from_if  = 1'b1;
    flag_from_ex   = 1'b1;
    idx_from_ex    = 8'h22;
    branch_from_ex = 1'b1;
    #1;
    exp_q.push_back(32'(mdl[34] >= 2));
    obs = 32'(prediction_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hazard_pred_same got %0h expected %0h", obs, exp_v); end
    mghr = shl(mghr, (mdl[34] >= 2) ? 1 : 0);
    mdl[34] = sat(mdl[34], 1'b1);
    cyc();
    flag_from_ex = 1'b0;
    pc_from_if   = 32'(((34 ^ mghr) & 255) << 2);
    #1;
    exp_q.push_back(32'(mdl[34] >= 2));
    exp_q.push_back(32'd34);
    obs = 32'(prediction_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hazard_pred_next got %0h expected %0h", obs, exp_v); end
    obs = 32'(idx_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hazard_idx got %0h expected %0h", obs, exp_v); end
    mghr = shl(mghr, (mdl[34] >= 2) ? 1 : 0);
    cyc();
    idle();
    exp_q.push_back(32'(mghr));
    obs = 32'(ghr_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hazard_ghr got %0h expected %0h", obs, exp_v); end
  endtask

  task automatic test_reset_mid_sweep;
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    flag_from_ex    = 1'b1;
    mispred_from_ex = 1'b1;
    idx_from_ex     = 8'h22;
    ghr_from_ex     = 8'h3C;
    branch_from_ex  = 1'b1;
    query_from_if   = 1'b1;
    pc_from_if      = 32'h88;
    for (int i = 0; i < 100; i++) cyc();
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    obs = 32'(dut.ptr_q); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_ptr got %0d expected %0d", obs, exp_v); end
    obs = 32'(ready_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_ready got %0h expected %0h", obs, exp_v); end
    obs = 32'(prediction_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_pred got %0h expected %0h", obs, exp_v); end
    obs = 32'(ghr_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_ghr got %0h expected %0h", obs, exp_v); end

    rst = 1'b1;
    cyc();
    exp_q.push_back(32'd0);
    obs = 32'(dut.ptr_q); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_ptr_restart got %0d expected %0d", obs, exp_v); end
    rst = 1'b0;
    n = 0;
    while (ready_to_if !== 1'b1 && n < 600) begin
      cyc();
      n++;
    end
    idle();
    exp_q.push_back(32'd256);
    obs = 32'(n); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_sweep_len got %0d expected %0d", obs, exp_v); end

    for (int i = 0; i < 256; i++) mdl[i] = 1;
    mghr = 0;
    exp_q.push_back(32'(mghr));
    obs = 32'(ghr_to_if); exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_ghr_after got %0h expected %0h", obs, exp_v); end
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(32'(mdl[i]));
      obs = 32'(dut.table_q[i]); exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL mid_table[%0d] got %0h expected %0h", i, obs, exp_v); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pc_from_if = 32'h0;
    idle();
    test_reset();
    test_saturation();
    test_history();
    test_recovery();
    test_hazard();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
